// File: rtl/sound_event_queue.sv
// Sound-effect command queue: latches game-event pulses, rate-limits repeats,
// arbitrates by priority and feeds start frames to the audio sequencer.
module sound_event_queue #(
  parameter int FRAME_BITS   = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int HOLDOFF      = 48828,
  parameter int START_PADDLE = 0,
  parameter int START_WALL   = 3,
  parameter int START_BRICK  = 6,
  parameter int START_LOST   = 9
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  EVENT_PADDLE,
  input  logic                  EVENT_WALL,
  input  logic                  EVENT_BRICK,
  input  logic                  EVENT_LOST,
  output logic                  CMD_VALID,
  input  logic                  CMD_READY,
  output logic [FRAME_BITS-1:0] CMD_FRAME,
  output logic [7:0]            DROP_COUNT
);

  localparam int PTR_BITS  = $clog2(FIFO_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;
  localparam int HOLD_BITS = $clog2(HOLDOFF + 1);
  localparam logic [HOLD_BITS-1:0] HOLD_LOAD = HOLD_BITS'(HOLDOFF);
  localparam logic [CNT_BITS-1:0]  FULL_COUNT = CNT_BITS'(FIFO_DEPTH);

  localparam int EV_PADDLE = 0;
  localparam int EV_WALL   = 1;
  localparam int EV_BRICK  = 2;
  localparam int EV_LOST   = 3;

  logic [FRAME_BITS-1:0]     fifoMem [FIFO_DEPTH];
  logic [PTR_BITS-1:0]       rdPtrReg;
  logic [PTR_BITS-1:0]       wrPtrReg;
  logic [CNT_BITS-1:0]       countReg;
  logic [3:0]                pendingReg;
  logic [3:0]                pendingNext;
  logic [3:0][HOLD_BITS-1:0] holdReg;
  logic [7:0]                dropReg;
  logic [7:0]                dropNext;

  logic [3:0]            eventPulse;
  logic [3:0]            holdIdle;
  logic [3:0]            acceptMask;
  logic [3:0]            dropMask;
  logic [3:0]            pushSel;
  logic [FRAME_BITS-1:0] pushFrame;
  logic                  pop;
  logic                  push;
  logic                  flush;
  logic                  roomFree;
  logic [2:0]            dropAdd;
  logic [8:0]            dropSum;

  assign eventPulse = {EVENT_LOST, EVENT_BRICK, EVENT_WALL, EVENT_PADDLE};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : genHoldIdle
      assign holdIdle[gi] = (holdReg[gi] == '0);
    end
  endgenerate

  assign CMD_VALID  = (countReg != '0);
  assign CMD_FRAME  = CMD_VALID ? fifoMem[rdPtrReg] : '0;
  assign DROP_COUNT = dropReg;

  assign pop      = CMD_VALID && CMD_READY;
  assign flush    = pendingReg[EV_LOST];
  assign roomFree = (countReg != FULL_COUNT) || pop;

  // LOST bypasses the full check because it rebuilds the queue from scratch.
  always_comb begin
    pushSel   = '0;
    pushFrame = '0;
    if (flush) begin
      pushSel[EV_LOST] = 1'b1;
    end else if (roomFree) begin
      if (pendingReg[EV_BRICK]) begin
        pushSel[EV_BRICK] = 1'b1;
        pushFrame         = FRAME_BITS'(START_BRICK);
      end else if (pendingReg[EV_PADDLE]) begin
        pushSel[EV_PADDLE] = 1'b1;
        pushFrame          = FRAME_BITS'(START_PADDLE);
      end else if (pendingReg[EV_WALL]) begin
        pushSel[EV_WALL] = 1'b1;
        pushFrame        = FRAME_BITS'(START_WALL);
      end
    end
  end

  assign push = |pushSel[2:0];

  // A pulse on an already-pending event is coalesced, so it neither sets nor counts.
  assign acceptMask  = eventPulse & holdIdle & ~pendingReg;
  assign dropMask    = eventPulse & ~holdIdle;
  assign pendingNext = flush ? 4'b0000 : ((pendingReg & ~pushSel) | acceptMask);

  assign dropAdd  = {2'b00, dropMask[0]} + {2'b00, dropMask[1]}
                  + {2'b00, dropMask[2]} + {2'b00, dropMask[3]};
  assign dropSum  = {1'b0, dropReg} + {6'b000000, dropAdd};
  assign dropNext = dropSum[8] ? 8'hFF : dropSum[7:0];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pendingReg <= '0;
      dropReg    <= '0;
      holdReg    <= '0;
    end else begin
      pendingReg <= pendingNext;
      dropReg    <= dropNext;
      for (int i = 0; i < 4; i++) begin
        if (pushSel[i]) begin
          holdReg[i] <= HOLD_LOAD;
        end else if (!holdIdle[i]) begin
          holdReg[i] <= holdReg[i] - HOLD_BITS'(1);
        end
      end
    end
  end

  // A pop during a flush is a real transfer of the old head; the queue still ends with one entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rdPtrReg <= '0;
      wrPtrReg <= '0;
      countReg <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifoMem[i] <= '0;
      end
    end else if (flush) begin
      fifoMem[0] <= FRAME_BITS'(START_LOST);
      rdPtrReg   <= '0;
      wrPtrReg   <= PTR_BITS'(1);
      countReg   <= CNT_BITS'(1);
    end else begin
      if (push) begin
        fifoMem[wrPtrReg] <= pushFrame;
        wrPtrReg          <= wrPtrReg + PTR_BITS'(1);
      end
      if (pop) begin
        rdPtrReg <= rdPtrReg + PTR_BITS'(1);
      end
      countReg <= countReg + CNT_BITS'(push) - CNT_BITS'(pop);
    end
  end

endmodule
